// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states,
// and the request legality helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Stores only have signed-size encodings; BU/HU are load-only.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      case (f3)
         F3_B, F3_H, F3_W: f3_legal = 1'b1;
         F3_BU, F3_HU:     f3_legal = !we;
         default:          f3_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane steering: extracts/extends load data from a memory word
// and merges sub-word store data into a captured word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{addr_lo, 3'b000} +: 8];
   assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      load_val   = word;
      store_word = word;
      case (funct3)
         F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_val = {24'h0, byte_sel};
         F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_val = {16'h0, half_sel};
         default: load_val = word;
      endcase
      case (funct3)
         F3_B:    store_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
         F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         F3_W:    store_word = wdata;
         default: store_word = word;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time onto a word-wide data memory port,
// with sub-word stores done as read-modify-write.
module lsu
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   state_t      state, state_nxt;
   logic        lat_we, err_q;
   logic [2:0]  lat_f3;
   logic [31:0] lat_addr, lat_wdata, word_q;
   logic [31:0] load_val, store_word;
   logic [32:0] word_end;
   logic        req_err, accept;

   // Word end computed one bit wider so addresses near 2^32 cannot wrap into range.
   assign word_end = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
   assign req_err  = !f3_legal(req_we, req_funct3)
                   || ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
                   || (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
                   || (word_end >= 33'(MEM_BYTES));
   assign accept   = (state == IDLE) && req_valid;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state <= IDLE;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) err_q <= req_err;
      end
   end

   // NOTE: datapath registers carry no reset; they are always written before being used.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we    <= req_we;
         lat_f3    <= req_funct3;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
      end
      if (state == READ) word_q <= mem_rd;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)                             state_nxt = RESP;
               else if (req_we && req_funct3 == F3_W)   state_nxt = WRITE;
               else                                     state_nxt = READ;
            end
         end
         READ:    state_nxt = lat_we ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   lsu_align u_align (
      .funct3     (lat_f3),
      .addr_lo    (lat_addr[1:0]),
      .word       (word_q),
      .wdata      (lat_wdata),
      .load_val   (load_val),
      .store_word (store_word)
   );

   // Port strobes and the response are gated by rst so a reset edge never commits or reports.
   always_comb begin
      req_ready  = (state == IDLE) && !rst;
      MemRead    = (state == READ) && !rst;
      MemWrite   = (state == WRITE) && !rst;
      mem_addr   = 32'h0;
      mem_wd     = 32'h0;
      resp_valid = (state == RESP) && !rst;
      resp_err   = 1'b0;
      resp_rdata = 32'h0;
      if (state == READ || state == WRITE) mem_addr = {lat_addr[31:2], 2'b00};
      if (state == WRITE) mem_wd = store_word;
      if (resp_valid) begin
         resp_err = err_q;
         if (!err_q && !lat_we) resp_rdata = load_val;
      end
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the CPU datapath: the initiator side of the data-memory port. Accepts one load or store request at a time from the execute stage. Drives the word-wide memory port (MemRead/MemWrite, 32-bit address, write data, combinational read data). Handles byte/halfword loads with sign or zero extension, and implements sub-word stores as read-modify-write, since the memory only writes whole 32-bit words.

## Interface
- MEM_BYTES, 1024: data-memory size in bytes. Any access whose word end exceeds this size is an error.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are legal for loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned, out of range, or illegal funct3; qualified by resp_valid
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable; the memory commits on the clk edge
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
- mem_wd  out  32  write word
- mem_rd  in  32  read word, combinational from mem_addr while MemRead=1

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata.
  - An error request goes to RESP with resp_err=1 and makes no memory access. Error conditions:
    - illegal funct3 (incl. BU/HU store);
    - H with addr[0]≠0;
    - W with addr[1:0]≠0;
    - aligned address + 3 ≥ MEM_BYTES.
  - A load, SB or SH goes to READ. SW goes to WRITE.
- **READ**
  - MemRead=1; capture mem_rd into the word register.
  - Load goes to RESP. SB/SH goes to WRITE.
- **WRITE**
  - MemWrite=1.
  - mem_wd for SW = wdata.
  - mem_wd for SB = captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - mem_wd for SH = captured word with halfword lane addr[1] replaced by wdata[15:0].
  - Next state RESP.
- **RESP**
  - resp_valid=1, resp_rdata/resp_err driven; next state IDLE.
- Load extraction uses little-endian lanes:
  - B/BU: byte mem_rd[8·addr[1:0]+:8], sign- or zero-extended.
  - H/HU: mem_rd[16·addr[1]+:16], sign- or zero-extended.
  - W: whole word.
- Outside READ/WRITE: MemRead=0, MemWrite=0, mem_addr=0, mem_wd=0.

## Timing
- Reset values: state IDLE, req_ready=0 while rst=1, resp_valid=0, resp_rdata=0, resp_err=0, MemRead=0, MemWrite=0, mem_addr=0, mem_wd=0.
- Accept at edge k. Latency to resp_valid:
  - load: RESP in cycle k+2;
  - SB/SH: RESP in cycle k+3;
  - SW: RESP in cycle k+2;
  - error: RESP in cycle k+1.
- Throughput: one request in flight. req_ready=0 from the cycle after accept through RESP. A new request is accepted in IDLE only.
- Response has no backpressure: resp_valid is a single-cycle pulse.
- Request signals are don't-care after acceptance.
- Reset mid-operation:
  - MemRead and MemWrite are gated by !rst, so no write commits on an edge where rst=1.
  - The in-flight request is dropped with no response; state returns to IDLE.
- RMW ordering: the READ capture and the WRITE commit are consecutive cycles. No other master exists, so atomicity is guaranteed.

## Structure
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum.
- Sub-module lsu_align: purely combinational. Inputs are funct3, addr[1:0], word, and wdata. Outputs are the extracted/extended load value and the merged store word. The FSM stays in the lsu top.

## Test plan
- Memory preloaded with word 0x8877_6655 at 0x10:
  - LB 0x13 → resp_rdata 0xFFFF_FF88, err=0, resp_valid 2 cycles after accept;
  - LBU 0x13 → 0x0000_0088.
- LH 0x12 → 0xFFFF_8877; LHU 0x10 → 0x0000_6655; LW 0x10 → 0x8877_6655.
- SB 0x11 with wdata 0x0000_00AB over 0x8877_6655:
  - exactly one MemRead cycle, then one MemWrite cycle with mem_wd 0x8877_AB55;
  - a subsequent LW returns 0x8877_AB55.
- SW 0x20 with wdata 0xDEAD_BEEF:
  - no MemRead, MemWrite for one cycle, resp_valid at k+2;
  - LW 0x20 returns 0xDEAD_BEEF.
- Error requests: LW 0x22, LH 0x31, store funct3=100, LW 0x3FC with MEM_BYTES=1020. Each gives resp_err=1 at k+1, resp_rdata=0, and MemRead=MemWrite=0 throughout.
- rst asserted in the WRITE cycle of an SB:
  - MemWrite stays 0 and memory is unchanged;
  - no resp_valid;
  - req_ready=1 in the first cycle after rst deasserts.
